// File: rtl/mul_red_pipe.sv
// Pipelined dual-mode modular multiplier: packed 12-bit products mod KQ or one 23-bit product mod DQ per lane.
// Optional sticky operand range check is enabled by defining MUL_RED_RANGE_CHECK_EN.
module mul_red_pipe #(
  parameter int LANES  = 2,
  parameter int KQ     = 3329,
  parameter int DQ     = 8380417,
  parameter int TW_DLY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [24*LANES-1:0]   a,
  input  logic [24*LANES-1:0]   w,
  input  logic [LANES-1:0]      mode,
  input  logic                  tw_dly_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [24*LANES-1:0]   result,
  output logic                  range_err
);

  localparam int LW = 24 * LANES;
  // Barrett constants: floor(2^k / q) with k covering the full product width, so one final subtract suffices.
  localparam logic [63:0]  KQ_W  = 64'(KQ);
  localparam logic [63:0]  KMU_W = (64'd1 << 24) / KQ_W;
  localparam logic [63:0]  DQ_W  = 64'(DQ);
  localparam logic [127:0] DMU_W = (128'd1 << 46) / 128'(DQ);

  function automatic logic [23:0] k_mul(input logic [11:0] x, input logic [11:0] y);
    return {12'd0, x} * {12'd0, y};
  endfunction

  function automatic logic [45:0] d_mul(input logic [22:0] x, input logic [22:0] y);
    return {23'd0, x} * {23'd0, y};
  endfunction

  function automatic logic [12:0] k_qhat(input logic [23:0] x);
    logic [63:0] t;
    t = {40'd0, x} * KMU_W;
    return 13'(t >> 24);
  endfunction

  function automatic logic [23:0] d_qhat(input logic [45:0] x);
    logic [127:0] t;
    t = {82'd0, x} * DMU_W;
    return 24'(t >> 46);
  endfunction

  function automatic logic [12:0] k_rem(input logic [23:0] x, input logic [12:0] qh);
    logic [63:0] t;
    t = {40'd0, x} - {51'd0, qh} * KQ_W;
    return 13'(t);
  endfunction

  function automatic logic [23:0] d_rem(input logic [45:0] x, input logic [23:0] qh);
    logic [63:0] t;
    t = {18'd0, x} - {40'd0, qh} * DQ_W;
    return 24'(t);
  endfunction

  function automatic logic [11:0] k_fin(input logic [12:0] r);
    if (r >= 13'(KQ_W)) return 12'(r - 13'(KQ_W));
    else                return r[11:0];
  endfunction

  function automatic logic [22:0] d_fin(input logic [23:0] r);
    if (r >= 24'(DQ_W)) return 23'(r - 24'(DQ_W));
    else                return r[22:0];
  endfunction

  logic                  stall_s, adv_s, acc_s;
  logic [LW-1:0]         w_sel_s;
  logic [LW-1:0]         tw_line_r [TW_DLY];

  logic                  s1_vld_r, s2_vld_r, s3_vld_r, s4_vld_r, out_vld_r;
  logic [LW-1:0]         s1_a_r, s1_w_r, result_r;
  logic [LANES-1:0]      s1_mode_r, s2_mode_r, s3_mode_r, s4_mode_r;
  logic [48*LANES-1:0]   s2_prod_s, s2_prod_r, s3_prod_r;
  logic [26*LANES-1:0]   s3_qh_s, s3_qh_r, s4_red_s, s4_red_r;
  logic [LW-1:0]         res_s;

  assign stall_s   = out_vld_r & ~out_ready;
  assign adv_s     = ~stall_s;
  assign acc_s     = in_valid & adv_s;
  assign in_ready  = adv_s;
  assign out_valid = out_vld_r;
  assign result    = result_r;
  assign w_sel_s   = tw_dly_sel ? tw_line_r[TW_DLY-1] : w;

  // Twiddle delay line, shifts only on accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TW_DLY; i++) tw_line_r[i] <= '0;
    end else if (acc_s) begin
      tw_line_r[0] <= w;
      for (int i = 1; i < TW_DLY; i++) tw_line_r[i] <= tw_line_r[i-1];
    end
  end

  // Per-lane datapath between pipeline registers; each lane uses its own piped mode tag.
  always_comb begin
    s2_prod_s = '0;
    s3_qh_s   = '0;
    s4_red_s  = '0;
    res_s     = '0;
    for (int l = 0; l < LANES; l++) begin
      if (s1_mode_r[l]) begin
        s2_prod_s[48*l +: 48] = {2'b00, d_mul(s1_a_r[24*l +: 23], s1_w_r[24*l +: 23])};
      end else begin
        s2_prod_s[48*l +: 48] = {k_mul(s1_a_r[24*l+12 +: 12], s1_w_r[24*l+12 +: 12]),
                                 k_mul(s1_a_r[24*l +: 12], s1_w_r[24*l +: 12])};
      end
      if (s2_mode_r[l]) begin
        s3_qh_s[26*l +: 26] = {2'b00, d_qhat(s2_prod_r[48*l +: 46])};
      end else begin
        s3_qh_s[26*l +: 26] = {k_qhat(s2_prod_r[48*l+24 +: 24]), k_qhat(s2_prod_r[48*l +: 24])};
      end
      if (s3_mode_r[l]) begin
        s4_red_s[26*l +: 26] = {2'b00, d_rem(s3_prod_r[48*l +: 46], s3_qh_r[26*l +: 24])};
      end else begin
        s4_red_s[26*l +: 26] = {k_rem(s3_prod_r[48*l+24 +: 24], s3_qh_r[26*l+13 +: 13]),
                                k_rem(s3_prod_r[48*l +: 24], s3_qh_r[26*l +: 13])};
      end
      if (s4_mode_r[l]) begin
        res_s[24*l +: 24] = {1'b0, d_fin(s4_red_r[26*l +: 24])};
      end else begin
        res_s[24*l +: 24] = {k_fin(s4_red_r[26*l+13 +: 13]), k_fin(s4_red_r[26*l +: 13])};
      end
    end
  end

  // Pipeline registers: operands, products, quotient estimate, remainder, result; all hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_r  <= 1'b0;  s2_vld_r  <= 1'b0;  s3_vld_r <= 1'b0;
      s4_vld_r  <= 1'b0;  out_vld_r <= 1'b0;
      s1_a_r    <= '0;    s1_w_r    <= '0;    s1_mode_r <= '0;
      s2_prod_r <= '0;    s2_mode_r <= '0;
      s3_prod_r <= '0;    s3_qh_r   <= '0;    s3_mode_r <= '0;
      s4_red_r  <= '0;    s4_mode_r <= '0;
      result_r  <= '0;
    end else if (adv_s) begin
      s1_vld_r  <= in_valid;
      s1_a_r    <= a;
      s1_w_r    <= w_sel_s;
      s1_mode_r <= mode;
      s2_vld_r  <= s1_vld_r;
      s2_prod_r <= s2_prod_s;
      s2_mode_r <= s1_mode_r;
      s3_vld_r  <= s2_vld_r;
      s3_prod_r <= s2_prod_r;
      s3_qh_r   <= s3_qh_s;
      s3_mode_r <= s2_mode_r;
      s4_vld_r  <= s3_vld_r;
      s4_red_r  <= s4_red_s;
      s4_mode_r <= s3_mode_r;
      out_vld_r <= s4_vld_r;
      result_r  <= res_s;
    end
  end

`ifdef MUL_RED_RANGE_CHECK_EN
  localparam logic [11:0] KQ12 = 12'(KQ);
  localparam logic [22:0] DQ23 = 23'(DQ);
  logic range_hit_s, range_err_r;

  // Flags any operand at or above its lane's modulus on the beat being offered.
  always_comb begin
    range_hit_s = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (mode[l]) begin
        range_hit_s = range_hit_s | (a[24*l +: 23] >= DQ23) | (w_sel_s[24*l +: 23] >= DQ23);
      end else begin
        range_hit_s = range_hit_s | (a[24*l+12 +: 12] >= KQ12) | (a[24*l +: 12] >= KQ12)
                                  | (w_sel_s[24*l+12 +: 12] >= KQ12) | (w_sel_s[24*l +: 12] >= KQ12);
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      range_err_r <= 1'b0;
    end else if (acc_s && range_hit_s) begin
      range_err_r <= 1'b1;
    end
  end

  assign range_err = range_err_r;
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: doc/mul_red_pipe.md
Name: mul_red_pipe

Overview:
Parametrised pipelined modular multiplier for the unified Kyber/Dilithium NTT datapath.
- LANES independent 24-bit slots.
- Each slot runs in one of two modes:
  - K-mode: two packed 12-bit products mod KQ.
  - D-mode: one 23-bit product mod DQ.
- Adds what the previous generation lacked: valid/ready handshake with backpressure, a per-lane mode tag that travels with its data, and selectable delayed twiddles.
- Sits between the butterfly add/sub stage and the writeback mux in each PE.

Parameters:
LANES, 2, number of 24-bit multiply slots
KQ, 3329, K-mode modulus (12-bit)
DQ, 8380417, D-mode modulus (23-bit)
TW_DLY, 1, twiddle delay in cycles applied when tw_dly_sel=1 (1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts beat this cycle
a  in  24*LANES  operands; lane i = a[24i+23:24i]; K-mode {aH,aL} 12b each
w  in  24*LANES  twiddles, same packing
mode  in  LANES  per-lane: 0 = K-mode, 1 = D-mode
tw_dly_sel  in  1  1 = use w delayed by TW_DLY accepted beats (INTT ordering)
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
result  out  24*LANES  K-mode {rH,rL}; D-mode {1'b0,r[22:0]}
range_err  out  1  sticky operand range error (see Optional Feature)

Behaviour:
- Reset: synchronous on rst=1 at the clock edge. Clears all pipeline valid bits, data registers, twiddle delay line and range_err.
- Reset outputs: out_valid=0, result=0, range_err=0, in_ready=1. Any op in flight when rst is asserted is discarded and never emerges.
- Pipeline: 4 stages, fixed.
  - S1: register operands, selected w and mode.
  - S2: partial products.
  - S3: reduction step 1.
  - S4: final conditional subtract, registered result.
- Latency: a beat accepted at edge n gives out_valid=1 from edge n+4, provided there is no stall.
- Handshake:
  - Accept occurs when in_valid & in_ready.
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, every stage holds: result and out_valid stay stable, and the twiddle delay line does not advance.
  - Bubbles (in_valid=0) advance as invalid slots.
- Throughput: 1 beat/cycle when out_ready=1.
- Twiddle delay line:
  - A TW_DLY-deep shift register of w that advances only on accept.
  - tw_dly_sel is sampled per accepted beat.
  - Before TW_DLY accepts have occurred since reset, the delayed value is 0.
- K-mode arithmetic, per 12-bit half: r = (a_half * w_half) mod KQ. Inputs are < KQ; output lies in [0, KQ-1].
- D-mode arithmetic: r = (a[22:0] * w[22:0]) mod DQ using the full 46-bit product; output lies in [0, DQ-1].
  - a[23] and w[23] are ignored.
- Mode tag:
  - Each lane's mode is captured at accept and piped with its data, so results use the mode in force at accept.
  - Mixed modes across lanes in one beat are legal.
  - Back-to-back beats with differing modes must not corrupt each other.
- Out-of-range inputs (>= modulus) still produce a result congruent to a*w mod q in [0, q-1].

Optional Feature:
Macro MUL_RED_RANGE_CHECK_EN.
- Defined: on each accept, range_err is set if any K-mode half of a or w is >= KQ, or any D-mode a[22:0]/w[22:0] is >= DQ. It stays set until rst.
- Not defined: range_err is tied to 0 and no compare logic is synthesised.
- Datapath results are identical either way.

Test Plan:
- K-mode, lane0: a={3328,2}, w={3328,1664}, out_ready=1 -> result={12'd1,12'd3328}. out_valid exactly 4 cycles after accept.
- D-mode, lane1: a=8380416, w=8380416 -> 1. Next beat a=2, w=4190209 -> 1. Next beat a=0, w=8380416 -> 0.
- Alternate mode every cycle on lane0 with {3328,3328}x{3328,3328} (K) and 8380416x8380416 (D) for 16 beats -> results alternate {1,1} and 1, in order, with no gaps.
- Backpressure:
  - Stimulus: stream 10 beats; drop out_ready for 3 cycles mid-stream.
  - Required: in_ready=0 while stalled, result held stable, no beat lost or duplicated, order preserved.
- tw_dly_sel=1, TW_DLY=1, w sequence 5,7,9 with a=1 (K-mode) -> results 0,5,7.
- Reset mid-operation:
  - Stimulus: assert rst with 3 beats in flight.
  - Required: out_valid=0 next cycle, no stale result emerges, range_err=0.
  - With MUL_RED_RANGE_CHECK_EN, K operand 3329 -> range_err=1 and it stays 1 until rst.
